tdc_readout: RTL
================

Name: tdc_readout

Overview:
- Receive-side counterpart of the read-phase control unit in the time-domain CIM accelerator.
- Per 54-tick read loop, measures how many clock ticks the column sense-amp output (sa_out) stays high inside the input_ctrl window. This is the time-domain MAC result.
- Accumulates the LOOPS per-loop samples of one read burst into a single digital result.
- Delivers the result over a valid/ready handshake to the downstream buffer or host.

Parameters:
- CNT_W, 5: per-window tick counter width; saturates at 2^CNT_W-1.
- ACC_W, 9: accumulator/result width; saturates at 2^ACC_W-1.
- LOOPS, 10: windows accumulated per read burst.
- SYNC_STAGES, 2: synchronizer depth on sa_out (minimum 2).

Ports:
- clk  in  1  system tick clock (same clock as the control unit).
- rst_n  in  1  reset, asynchronous, active-low.
- compute_sig  in  1  read burst active (from control unit).
- input_ctrl  in  1  per-loop measurement window (from control unit).
- sa_out  in  1  sense-amp output, asynchronous to clk.
- result_data  out  ACC_W  accumulated tick count of the last completed burst.
- result_valid  out  1  result_data valid.
- result_ready  in  1  consumer accepts result.
- abort_pulse  out  1  one-cycle pulse: burst ended before LOOPS windows.
- overrun  out  1  sticky: a burst completed while result_valid was still held.
- busy  out  1  high in ARMED or WINDOW.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Synchronizer and alignment flops are cleared.
- Alignment:
  - s_sa = sa_out passed through SYNC_STAGES flops.
  - d_win and d_comp = input_ctrl and compute_sig delayed by the same SYNC_STAGES flops, so that window and data stay tick-aligned.
  - All logic below uses only s_sa, d_win and d_comp.
- States:
  - IDLE: cnt=0, acc=0, loops=0. d_comp rising edge -> ARMED.
  - ARMED:
    - d_win=1 -> WINDOW; this cycle already counts.
    - d_comp=0 -> IDLE. If 0<loops<LOOPS, raise abort_pulse; if loops==0, no pulse.
  - WINDOW:
    - Each edge with s_sa=1: cnt<=cnt+1, saturating.
    - On d_win falling edge: acc<=sat(acc+cnt), cnt<=0, loops<=loops+1, -> ARMED.
    - If loops+1==LOOPS: result_data<=sat(acc+cnt) and result_valid<=1 on that edge (visible next cycle). Then go to DRAIN, not ARMED.
    - d_comp falling while in WINDOW: partial sample discarded, abort_pulse, -> IDLE.
  - DRAIN:
    - Wait for d_comp=0, then -> IDLE.
    - Any further input_ctrl windows in the same burst are ignored. This covers the 1-tick window the control unit emits on its READ->RESET transition.
- Handshake:
  - result_valid held with result_data stable until the edge where result_valid && result_ready; cleared there.
  - A new burst may start while valid is still pending.
- Overrun:
  - A burst completes while result_valid=1 and result_ready=0 on that edge: the old result is retained, the new one is dropped, overrun<=1.
  - Completion and handshake on the same edge: the handshake wins and the new result loads; no overrun.
  - overrun clears on the next accepted handshake.
- Latency: result_valid rises SYNC_STAGES+1 cycles after the last raw input_ctrl falling edge.
- Reset mid-burst: immediate return to IDLE. A pending result is lost; no abort_pulse.

Optional Feature:
- Macro: TDC_GLITCH_FILTER_EN.
- Defined:
  - s_sa is replaced by a 2-tick majority filter: the filtered value changes only after 2 consecutive equal synchronized samples.
  - d_win and d_comp gain one extra delay stage to stay aligned; latency becomes SYNC_STAGES+2.
- Undefined: raw synchronized s_sa is used; no extra delay.

Test Plan:
- Nominal burst: 10 loops of 54 ticks, input_ctrl high 30 ticks per loop, sa_out high for the first 12 ticks of each window -> result_data=120, one result_valid. Handshake with result_ready=1 on the first valid cycle.
- Full-scale: sa_out held high, 30-tick windows, plus the 11th 1-tick trailing window -> result_data=300; trailing window ignored (no 301).
- Back-pressure/overrun:
  - result_ready=0 through burst 1 (sa 5 ticks/loop) and burst 2 (sa 7 ticks/loop) -> result_data stays 50, overrun=1.
  - Then assert ready -> valid clears and overrun clears.
- Abort: compute_sig drops after the 4th window -> abort_pulse for exactly 1 cycle, no result_valid, state IDLE. The next full burst of 3 ticks/loop gives 30.
- Async reset: assert rst_n low for 3 ticks mid-window in loop 6 -> all outputs 0. The following clean burst of 8 ticks/loop gives 80.
- Glitch filter (macro on): 1-tick sa_out pulses every 4 ticks inside windows -> result_data=0. With the macro off, the same stimulus gives a nonzero count (8 per 30-tick window, 80 total).

Source files
------------

// File: rtl/tdc_readout.sv
// Time-domain CIM readout: measures sa_out high-time inside each input_ctrl window and accumulates a read burst.
// Optional majority glitch filter on sa_out enabled by defining TDC_GLITCH_FILTER_EN.
module tdc_readout #(
  parameter int CNT_W       = 5,
  parameter int ACC_W       = 9,
  parameter int LOOPS       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             compute_sig,
  input  logic             input_ctrl,
  input  logic             sa_out,
  output logic [ACC_W-1:0] result_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             abort_pulse,
  output logic             overrun,
  output logic             busy
);

`ifdef TDC_GLITCH_FILTER_EN
  localparam int DLY = SYNC_STAGES + 1;
`else
  localparam int DLY = SYNC_STAGES;
`endif
  localparam int LW = $clog2(LOOPS + 1);

  typedef enum logic [1:0] {IDLE, ARMED, WINDOW, DRAIN} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sa_sync;
  logic [DLY-1:0]         win_dly;
  logic [DLY-1:0]         comp_dly;
  logic                   s_sa;
  logic                   d_win;
  logic                   d_comp;
  logic                   d_comp_q;
  logic [CNT_W-1:0]       cnt;
  logic [ACC_W-1:0]       acc;
  logic [LW-1:0]          loops;
  logic [ACC_W-1:0]       sum;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - CNT_W){1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  // Window and burst flags travel through the same depth as the data so all three stay tick-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_sync  <= '0;
      win_dly  <= '0;
      comp_dly <= '0;
    end else begin
      sa_sync  <= {sa_sync[SYNC_STAGES-2:0], sa_out};
      win_dly  <= {win_dly[DLY-2:0], input_ctrl};
      comp_dly <= {comp_dly[DLY-2:0], compute_sig};
    end
  end

`ifdef TDC_GLITCH_FILTER_EN
  logic sa_filt;

  // Filtered level follows the synchronizer only once two consecutive samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_filt <= 1'b0;
    end else if (sa_sync[SYNC_STAGES-1] == sa_sync[SYNC_STAGES-2]) begin
      sa_filt <= sa_sync[SYNC_STAGES-1];
    end else begin
      sa_filt <= sa_filt;
    end
  end

  assign s_sa = sa_filt;
`else
  assign s_sa = sa_sync[SYNC_STAGES-1];
`endif

  assign d_win  = win_dly[DLY-1];
  assign d_comp = comp_dly[DLY-1];
  assign sum    = sat_add(acc, cnt);

  // Burst FSM, accumulation and result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      loops        <= '0;
      d_comp_q     <= 1'b0;
      result_data  <= '0;
      result_valid <= 1'b0;
      abort_pulse  <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      abort_pulse <= 1'b0;
      d_comp_q    <= d_comp;
      if (result_valid && result_ready) begin
        result_valid <= 1'b0;
        overrun      <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt   <= '0;
          acc   <= '0;
          loops <= '0;
          if (d_comp && !d_comp_q) begin
            state <= ARMED;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ARMED: begin
          if (!d_comp) begin
            state       <= IDLE;
            busy        <= 1'b0;
            abort_pulse <= (loops != '0);
          end else if (d_win) begin
            state <= WINDOW;
            cnt   <= s_sa ? {{(CNT_W - 1){1'b0}}, 1'b1} : '0;
          end
        end
        WINDOW: begin
          if (!d_comp) begin
            state       <= IDLE;
            busy        <= 1'b0;
            abort_pulse <= 1'b1;
            cnt         <= '0;
          end else if (!d_win) begin
            acc   <= sum;
            cnt   <= '0;
            loops <= loops + 1'b1;
            if (loops == LW'(LOOPS - 1)) begin
              state <= DRAIN;
              busy  <= 1'b0;
              // A result still waiting for the consumer wins unless it is taken on this very edge.
              if (!result_valid || result_ready) begin
                result_data  <= sum;
                result_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state <= ARMED;
            end
          end else if (s_sa && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          busy <= 1'b0;
          if (!d_comp) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
